// File: rtl/retire_stage_pkg.sv
// Shared definitions for the retirement stage: widths, physical tags, ROB head
// packet and the per-consumer commit packets.
package retire_stage_pkg;

  localparam int XLEN   = 32;
  localparam int ROB_SZ = 16;
  localparam int PREG_W = 6;

  typedef struct packed {
    logic              valid;
    logic [PREG_W-1:0] phys;
  } TAG;

  typedef struct packed {
    logic            retire_en;
    TAG              retire_t;
    TAG              retire_t_old;
    logic            halt;
    logic            wr_mem;
    logic [4:0]      dest_reg_idx;
    logic [XLEN-1:0] NPC;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] rs2_value;
    logic            take_branch;
  } ROB_IR_PACKET;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    STORE_WAIT = 2'd1,
    FLUSH      = 2'd2,
    HALTED     = 2'd3
  } RETIRE_STATE;

  typedef struct packed {
    logic       wr_en;
    logic [4:0] idx;
    TAG         tag;
  } IR_MT_PACKET;

  typedef struct packed {
    logic free_en;
    TAG   tag;
  } IR_FL_PACKET;

  // The ROB advances its head only on retire_ack.
  typedef struct packed {
    logic retire_ack;
  } IR_ROB_PACKET;

  function automatic TAG make_tag(input logic valid, input logic [PREG_W-1:0] phys);
    TAG t;
    t.valid = valid;
    t.phys  = phys;
    return t;
  endfunction

endpackage

// File: rtl/retire_stage.sv
// In-order retirement of the ROB head: commits, store handshake, branch
// redirect with a one-cycle flush, and sticky halt.
//
// state      | meaning
// RUN        | head examined every cycle; commits when complete
// STORE_WAIT | store request outstanding, waiting for mem_ack
// FLUSH      | one dead cycle after a taken-branch redirect
// HALTED     | retirement stopped until reset
module retire_stage
  import retire_stage_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  ROB_IR_PACKET      rob_ir_packet,
  output logic              retire_ack,
  output logic              mt_wr_en,
  output logic [4:0]        mt_wr_idx,
  output TAG                mt_wr_tag,
  output logic              fl_free_en,
  output TAG                fl_free_tag,
  output logic              mem_req,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_ack,
  output logic              redirect_en,
  output logic [XLEN-1:0]   redirect_pc,
  output logic              wb_valid,
  output logic [4:0]        wb_reg_idx,
  output logic [XLEN-1:0]   wb_data,
  output logic [XLEN-1:0]   wb_NPC,
  output logic              halted,
  output logic [31:0]       retired_count
);

  RETIRE_STATE  state, state_nxt;
  logic         commit;
  IR_MT_PACKET  mt_pkt;
  IR_FL_PACKET  fl_pkt;
  IR_ROB_PACKET rob_pkt;

  always_comb begin
    state_nxt   = state;
    commit      = 1'b0;
    mem_req     = 1'b0;
    redirect_en = 1'b0;
    if (!reset) begin
      case (state)
        RUN: begin
          if (rob_ir_packet.retire_en) begin
            if (rob_ir_packet.wr_mem) begin
              mem_req = 1'b1;
              if (mem_ack) begin
                commit    = 1'b1;
                state_nxt = rob_ir_packet.halt ? HALTED : RUN;
              end else begin
                state_nxt = STORE_WAIT;
              end
            end else begin
              commit = 1'b1;
              if (rob_ir_packet.halt) begin
                state_nxt = HALTED;
              end else if (rob_ir_packet.take_branch) begin
                redirect_en = 1'b1;
                state_nxt   = FLUSH;
              end
            end
          end
        end
        // Head cannot change here: the ROB has not seen retire_ack.
        STORE_WAIT: begin
          mem_req = 1'b1;
          if (mem_ack) begin
            commit    = 1'b1;
            state_nxt = rob_ir_packet.halt ? HALTED : RUN;
          end
        end
        FLUSH:   state_nxt = RUN;
        HALTED:  state_nxt = HALTED;
        default: state_nxt = RUN;
      endcase
    end
  end

  // A halt entry commits but never touches the map or the free list.
  always_comb begin
    rob_pkt.retire_ack = commit;
    mt_pkt.wr_en   = commit && !rob_ir_packet.halt && rob_ir_packet.retire_t.valid &&
                     (rob_ir_packet.dest_reg_idx != 5'd0);
    mt_pkt.idx     = rob_ir_packet.dest_reg_idx;
    mt_pkt.tag     = rob_ir_packet.retire_t;
    fl_pkt.free_en = commit && !rob_ir_packet.halt && rob_ir_packet.retire_t_old.valid;
    fl_pkt.tag     = rob_ir_packet.retire_t_old;
  end

  assign retire_ack  = rob_pkt.retire_ack;
  assign wb_valid    = commit;
  assign mt_wr_en    = mt_pkt.wr_en;
  assign mt_wr_idx   = mt_pkt.idx;
  assign mt_wr_tag   = mt_pkt.tag;
  assign fl_free_en  = fl_pkt.free_en;
  assign fl_free_tag = fl_pkt.tag;
  assign mem_addr    = rob_ir_packet.result;
  assign mem_wdata   = rob_ir_packet.rs2_value;
  assign redirect_pc = rob_ir_packet.result;
  assign wb_reg_idx  = rob_ir_packet.dest_reg_idx;
  assign wb_data     = rob_ir_packet.result;
  assign wb_NPC      = rob_ir_packet.NPC;
  assign halted      = (state == HALTED) && !reset;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= RUN;
      retired_count <= 32'd0;
    end else begin
      state <= state_nxt;
      if (commit) retired_count <= retired_count + 32'd1;
    end
  end

endmodule

// File: doc/retire_stage.md
# retire_stage

In-order retirement stage consuming the ROB head entry. Each cycle it decides whether the head can commit. On commit it acknowledges the ROB, updates the architectural map, and releases the old physical tag to the free list. Stores are performed to data memory under a req/ack handshake before commit; taken branches raise a front-end redirect and a one-cycle flush; halt stops retirement permanently.

## Interface
Parameters:
- none; widths come from `XLEN, `ROB_SZ and TAG in the shared definitions.

Ports:
- clock  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- rob_ir_packet  in  ROB_IR_PACKET  ROB head fields: retire_en, retire_t, retire_t_old, halt, wr_mem, dest_reg_idx, NPC, result, rs2_value, take_branch.
- retire_ack  out  1  head committed this cycle; ROB advances head only on this.
- mt_wr_en  out  1  architectural map write.
- mt_wr_idx  out  5  architectural register (= dest_reg_idx).
- mt_wr_tag  out  TAG  new mapping (= retire_t).
- fl_free_en  out  1  return tag to free list.
- fl_free_tag  out  TAG  = retire_t_old.
- mem_req  out  1  store request.
- mem_addr  out  `XLEN  = result.
- mem_wdata  out  `XLEN  = rs2_value.
- mem_ack  in  1  store accepted.
- redirect_en  out  1  taken branch committed; flush pipeline.
- redirect_pc  out  `XLEN  target (= result).
- wb_valid  out  1  commit trace strobe.
- wb_reg_idx  out  5  trace destination.
- wb_data  out  `XLEN  trace value (= result).
- wb_NPC  out  `XLEN  trace NPC.
- halted  out  1  sticky halt.
- retired_count  out  32  committed-instruction counter.

## Operation
- State machine states: RUN, STORE_WAIT, FLUSH, HALTED. Reset state is RUN.
- "commit" means the following outputs are all driven this cycle:
  - retire_ack=1 and wb_valid=1.
  - fl_free_en = retire_t_old.valid.
  - mt_wr_en = retire_t.valid && dest_reg_idx!=0.
  - retired_count increments on the next edge.
- RUN, retire_en=0: all strobes are 0.
- RUN, retire_en=1, wr_mem=0: commit.
  - If halt=1, next state is HALTED. A halt entry never writes the map and never frees a tag.
  - Otherwise, if take_branch=1, redirect_en=1 with redirect_pc=result, and next state is FLUSH.
- RUN, retire_en=1, wr_mem=1: mem_req=1.
  - If mem_ack=1 the same cycle, commit and stay in RUN.
  - Otherwise go to STORE_WAIT with no commit.
- STORE_WAIT: mem_req stays high and mem_addr/mem_wdata track the head, which is unchanged because there was no ack.
  - On mem_ack: commit and return to RUN.
  - A store carrying halt=1 performs the store first, then enters HALTED.
- FLUSH: lasts one cycle. Every strobe is 0 and the head is ignored. Next state is RUN.
- HALTED: every strobe is 0 and halted=1 until reset.
- Data outputs are continuous copies of the head fields.
- At most one instruction commits per cycle.
- retired_count wraps modulo 2^32.

## Timing
- Every strobe (retire_ack, mt_wr_en, fl_free_en, mem_req, redirect_en, wb_valid) is combinational from the registered state and rob_ir_packet. Commit therefore has zero-cycle latency from a complete head.
- State and retired_count are registered.
- While reset is high, every strobe and halted is forced to 0. After the reset edge: state=RUN, retired_count=0, halted=0.
- Reset in STORE_WAIT: mem_req falls in the same cycle reset is seen. The pending store is abandoned with no commit.
- Handshake: mem_req is never withdrawn before mem_ack. mem_ack while mem_req=0 is ignored.
- Back-to-back commits: one per cycle in RUN.
- After a redirect, the earliest next commit is 2 cycles later (FLUSH, then RUN).
- mem_ack in the same cycle as a non-store head: ignored.

## Structure
- Shared definitions header gets:
  - RETIRE_STATE enum (RUN, STORE_WAIT, FLUSH, HALTED).
  - IR_MT_PACKET (wr_en, idx, tag).
  - IR_FL_PACKET (free_en, tag).
  - IR_ROB_PACKET (retire_ack). The ROB's head advance is to be gated on IR_ROB_PACKET.retire_ack.
- Single module, no sub-module. The state register and counter are small enough to stay inline.

## Test plan
- ALU commit: head complete, t=P12 valid, t_old=P3 valid, dest=5, result=0x2A → same cycle retire_ack=1, mt_wr_idx=5/tag P12, fl_free_tag=P3, wb_data=0x2A; retired_count 0→1.
- Store with delayed ack: wr_mem=1, result=0x100, rs2_value=0xDEAD; mem_ack after 3 cycles → mem_req high 4 cycles with addr 0x100 / data 0xDEAD, retire_ack only in the ack cycle, count +1.
- Taken branch: take_branch=1, result=0x400 → redirect_en=1, redirect_pc=0x400 for 1 cycle, no commit next cycle, next complete head commits 2 cycles later.
- Halt: halt=1 complete → commit, no map write, no free, halted=1 from the next cycle; subsequent complete heads are not acked.
- Reset in STORE_WAIT: reset during a pending store → mem_req=0 that cycle, retired_count=0, state RUN, with no spurious retire_ack.
- x0 destination plus invalid t_old: dest=0, t_old.valid=0 → retire_ack=1, mt_wr_en=0, fl_free_en=0.
